// File: rtl/rx_frame_ctrl_pkg.sv
// rtl/rx_frame_ctrl_pkg.sv - shared state encoding and frame constants for the serial receive controller
package rx_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        CHECK = 2'd3
    } state_t;

    localparam int OVS_DEFAULT = 16;
    // start + 8 data + stop; the start bit doubles as the completion marker
    localparam int FRAME_LEN   = 10;

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - free-running divider producing a one-cycle tick every DIV clocks
module baud_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/rx_frame_ctrl.sv
// rtl/rx_frame_ctrl.sv - 8N1 receiver sequencing an external 10-bit shift register, with valid/ack delivery
module rx_frame_ctrl
    import rx_frame_ctrl_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9_600,
    parameter int OVS    = OVS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic [FRAME_LEN-1:0] sh_q,
    output logic                 sh_ld3ff,
    output logic                 sh_en,
    output logic                 sh_si,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int DIV   = (CLK_HZ + (BAUD * OVS) / 2) / (BAUD * OVS);
    localparam int OVS_W = $clog2(OVS);
    localparam logic [OVS_W-1:0] MID  = OVS_W'(OVS / 2 - 1);
    localparam logic [OVS_W-1:0] LAST = OVS_W'(OVS - 1);

    logic             rxd_m, rxd_s, rxd_p;
    logic             tick;
    logic [OVS_W-1:0] ovs_cnt;
    state_t           state, state_n;
    logic             fresh;
    logic             shifted;
    logic             ovs_clr;
    logic             shift_now;

    baud_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // rxd_p is one cycle behind rxd_s so IDLE can see a genuine 1->0 edge
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_p <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
            rxd_p <= rxd_s;
        end
    end

    always_comb begin
        state_n   = state;
        ovs_clr   = 1'b0;
        shift_now = 1'b0;
        case (state)
            IDLE: begin
                if (rxd_p && !rxd_s) begin
                    state_n = START;
                    ovs_clr = 1'b1;
                end
            end
            START: begin
                if (tick && ovs_cnt == MID) begin
                    if (!rxd_s) begin
                        shift_now = 1'b1;
                        ovs_clr   = 1'b1;
                        state_n   = SHIFT;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            SHIFT: begin
                if (shifted && !sh_q[0]) begin
                    state_n = CHECK;
                end else if (tick && ovs_cnt == LAST) begin
                    shift_now = 1'b1;
                end
            end
            CHECK: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign sh_en    = shift_now & ~rst;
    assign sh_si    = rxd_s;
    assign sh_ld3ff = rst | (state == IDLE && fresh);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fresh     <= 1'b1;
            shifted   <= 1'b0;
            ovs_cnt   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state   <= state_n;
            fresh   <= (state != IDLE) && (state_n == IDLE);
            shifted <= shift_now;
            if (ovs_clr) begin
                ovs_cnt <= '0;
            end else if (tick) begin
                ovs_cnt <= ovs_cnt + OVS_W'(1);
            end
            // a delivery in the same cycle as an ack keeps the new byte valid
            if (state == CHECK) begin
                rx_data   <= sh_q[FRAME_LEN-2:1];
                frame_err <= ~sh_q[FRAME_LEN-1];
                rx_valid  <= 1'b1;
                overrun   <= overrun | (rx_valid & ~rx_ack);
            end else if (rx_ack && rx_valid) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
